// File: rtl/johnson_decoder.sv
// johnson_decoder: decodes a sampled Johnson code to a binary index and
// checks that successive samples follow the counter sequence. It reports
// lock status, step errors and a saturating error count.
module johnson_decoder #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_COUNT = 4,
  parameter bit          ALLOW_HOLD = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               j_in,
  input  logic                           valid_in,
  input  logic                           err_clr,
  output logic [$clog2(2*WIDTH)-1:0]     index,
  output logic                           valid_out,
  output logic                           legal,
  output logic                           step_err,
  output logic                           locked,
  output logic [7:0]                     err_count
);

  localparam int unsigned N  = 2 * WIDTH;
  localparam int unsigned IW = $clog2(2 * WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ref_q, ref_d;
  logic [GW-1:0]   good_q, good_d;
  logic [IW-1:0]   index_q, index_d;
  logic            legal_q, legal_d;
  logic            valid_out_q, valid_out_d;
  logic            step_err_q, step_err_d;
  logic            locked_q, locked_d;
  logic [7:0]      err_count_q, err_count_d;

  logic [CW-1:0]   trans_cnt;
  logic [CW-1:0]   pop_cnt;
  logic            dec_legal;
  logic [IW-1:0]   dec_index;
  logic [IW-1:0]   next_ref;
  logic            is_advance;
  logic            is_hold;
  logic            reach_lock;

  // Combinational decode of the current sample: legality, index, classification.
  always_comb begin
    trans_cnt = '0;
    pop_cnt   = '0;
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      trans_cnt = trans_cnt + CW'(j_in[i] ^ j_in[i+1]);
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      pop_cnt = pop_cnt + CW'(j_in[i]);
    end
    dec_legal = (trans_cnt <= CW'(1));
    if (!dec_legal) begin
      dec_index = '0;
    end else if (!j_in[WIDTH-1]) begin
      dec_index = IW'(pop_cnt);
    end else begin
      dec_index = IW'(N - 32'(pop_cnt));
    end
    next_ref   = (ref_q == IW'(N - 1)) ? '0 : ref_q + IW'(1);
    is_advance = dec_legal && (dec_index == next_ref);
    is_hold    = ALLOW_HOLD && dec_legal && (dec_index == ref_q);
    reach_lock = (32'(good_q) + 32'd1) >= LOCK_COUNT;
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: acquire in SEARCH, count advances in TRACK, hold in LOCKED.
  always_comb begin
    state_d = state_q;
    if (valid_in) begin
      case (state_q)
        SEARCH: begin
          if (dec_legal) state_d = TRACK;
        end
        TRACK: begin
          if (is_advance) begin
            if (reach_lock) state_d = LOCKED;
          end else if (!is_hold && !dec_legal) begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          if (!is_advance && !is_hold) state_d = dec_legal ? TRACK : SEARCH;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Output and datapath next values: reference tracking, error pulse and count.
  always_comb begin
    ref_d       = ref_q;
    good_d      = good_q;
    index_d     = index_q;
    legal_d     = legal_q;
    valid_out_d = 1'b0;
    step_err_d  = 1'b0;
    err_count_d = err_count_q;
    locked_d    = (state_d == LOCKED);
    if (valid_in) begin
      index_d     = dec_index;
      legal_d     = dec_legal;
      valid_out_d = 1'b1;
      case (state_q)
        SEARCH: begin
          if (dec_legal) begin
            ref_d  = dec_index;
            good_d = '0;
          end
        end
        TRACK: begin
          if (is_advance) begin
            ref_d  = dec_index;
            good_d = good_q + GW'(1);
          end else if (!is_hold) begin
            step_err_d = 1'b1;
            if (dec_legal) begin
              ref_d  = dec_index;
              good_d = '0;
            end
          end
        end
        LOCKED: begin
          if (is_advance) begin
            ref_d = dec_index;
          end else if (!is_hold) begin
            step_err_d = 1'b1;
            if (dec_legal) begin
              ref_d  = dec_index;
              good_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
    if (step_err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    // A clear coinciding with an error wins.
    if (err_clr) err_count_d = '0;
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ref_q       <= '0;
      good_q      <= '0;
      index_q     <= '0;
      legal_q     <= 1'b0;
      valid_out_q <= 1'b0;
      step_err_q  <= 1'b0;
      locked_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      ref_q       <= ref_d;
      good_q      <= good_d;
      index_q     <= index_d;
      legal_q     <= legal_d;
      valid_out_q <= valid_out_d;
      step_err_q  <= step_err_d;
      locked_q    <= locked_d;
      err_count_q <= err_count_d;
    end
  end

  assign index     = index_q;
  assign valid_out = valid_out_q;
  assign legal     = legal_q;
  assign step_err  = step_err_q;
  assign locked    = locked_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Testbench for johnson_decoder: two instances (hold allowed / hold rejected)
// driven with directed and random Johnson samples, compared to a table-based model.
module tb_johnson_decoder;

  localparam int W  = 4;
  localparam int N  = 2 * W;
  localparam int LC = 4;

  logic         clock;
  logic         reset;
  logic [W-1:0] j_in;
  logic         valid_in;
  logic         err_clr;

  logic [2:0]   index_o     [2];
  logic [1:0]   valid_out_o;
  logic [1:0]   legal_o;
  logic [1:0]   step_err_o;
  logic [1:0]   locked_o;
  logic [7:0]   err_count_o [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state, one slot per instance (0 = hold allowed, 1 = hold rejected).
  int m_state [2];
  int m_ref   [2];
  int m_good  [2];
  int m_idx   [2];
  int m_legal [2];
  int m_vout  [2];
  int m_serr  [2];
  int m_cnt   [2];

  logic [W-1:0] seq_tbl [N];
  int           pos;

  johnson_decoder #(.WIDTH(W), .LOCK_COUNT(LC), .ALLOW_HOLD(1'b1)) u_dut_hold (
    .clock(clock), .reset(reset), .j_in(j_in), .valid_in(valid_in), .err_clr(err_clr),
    .index(index_o[0]), .valid_out(valid_out_o[0]), .legal(legal_o[0]),
    .step_err(step_err_o[0]), .locked(locked_o[0]), .err_count(err_count_o[0]));

  johnson_decoder #(.WIDTH(W), .LOCK_COUNT(LC), .ALLOW_HOLD(1'b0)) u_dut_strict (
    .clock(clock), .reset(reset), .j_in(j_in), .valid_in(valid_in), .err_clr(err_clr),
    .index(index_o[1]), .valid_out(valid_out_o[1]), .legal(legal_o[1]),
    .step_err(step_err_o[1]), .locked(locked_o[1]), .err_count(err_count_o[1]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_ref[k] = 0; m_good[k] = 0; m_idx[k] = 0;
      m_legal[k] = 0; m_vout[k] = 0; m_serr[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // Sequence position of a code, or -1 when it is not in the Johnson sequence.
  function automatic int lookup(input logic [W-1:0] code);
    int r = -1;
    for (int p = 0; p < N; p++) if (seq_tbl[p] == code) r = p;
    return r;
  endfunction

  task automatic model_step(input logic [W-1:0] code, input logic v, input logic clr);
    int  p;
    bit  lg, adv, hld, allow;
    p  = lookup(code);
    lg = (p >= 0);
    for (int k = 0; k < 2; k++) begin
      allow     = (k == 0);
      m_vout[k] = 0;
      m_serr[k] = 0;
      if (v) begin
        m_vout[k]  = 1;
        m_legal[k] = lg;
        m_idx[k]   = lg ? p : 0;
        adv = lg && (m_idx[k] == (m_ref[k] + 1) % N);
        hld = allow && lg && (m_idx[k] == m_ref[k]);
        if (m_state[k] == 0) begin
          if (lg) begin m_ref[k] = m_idx[k]; m_good[k] = 0; m_state[k] = 1; end
        end else if (adv) begin
          m_ref[k] = m_idx[k];
          if (m_state[k] == 1) begin
            m_good[k]++;
            if (m_good[k] == LC) m_state[k] = 2;
          end
        end else if (!hld) begin
          m_serr[k] = 1;
          if (lg) begin m_ref[k] = m_idx[k]; m_good[k] = 0; m_state[k] = 1; end
          else m_state[k] = 0;
        end
      end
      if (m_serr[k] != 0 && m_cnt[k] < 255) m_cnt[k]++;
      if (clr) m_cnt[k] = 0;
    end
  endtask

  task automatic check_all();
    string nm;
    for (int k = 0; k < 2; k++) begin
      nm = (k == 0) ? "hold" : "strict";
      check_eq({nm, "_index"},     index_o[k],     m_idx[k]);
      check_eq({nm, "_valid_out"}, valid_out_o[k], m_vout[k]);
      check_eq({nm, "_legal"},     legal_o[k],     m_legal[k]);
      check_eq({nm, "_step_err"},  step_err_o[k],  m_serr[k]);
      check_eq({nm, "_locked"},    locked_o[k],    (m_state[k] == 2) ? 1 : 0);
      check_eq({nm, "_err_count"}, err_count_o[k], m_cnt[k]);
    end
  endtask

  task automatic drive(input logic [W-1:0] code, input logic v, input logic clr);
    @(negedge clock);
    j_in = code; valid_in = v; err_clr = clr;
    @(posedge clock);
    model_step(code, v, clr);
    #1 check_all();
  endtask

  task automatic drive_pos(input int p);
    logic [W-1:0] c;
    c = seq_tbl[p % N];
    drive(c, 1'b1, 1'b0);
  endtask

  initial begin
    logic [W-1:0] c;
    int r;
    c = '0;
    for (int p = 0; p < N; p++) begin
      seq_tbl[p] = c;
      c = {c[W-2:0], ~c[W-1]};
    end
    reset = 1'b1; j_in = '0; valid_in = 1'b0; err_clr = 1'b0;
    model_reset();

    // Reset held across edges with activity on the inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      j_in = seq_tbl[i]; valid_in = 1'b1;
      @(posedge clock);
      #1 check_all();
    end
    @(negedge clock);
    valid_in = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive(W'($urandom_range(0, 15)), 1'b0, 1'b0);

    // Clean sequence with wrap; lock on the fifth sample.
    for (int p = 0; p <= N; p++) begin
      drive_pos(p);
      if (p == 4) check_eq("lock_on_5th", locked_o[0], 1);
    end

    // Illegal code while locked, then re-acquire at index 2.
    drive(4'b0101, 1'b1, 1'b0);
    check_eq("illegal_index0", index_o[0], 0);
    drive_pos(2);
    // Skip while tracking, then continue in order to relock on 0000.
    drive_pos(4);
    for (int p = 5; p <= 8; p++) drive_pos(p);

    // Hold behaviour: repeats of 0111.
    for (int p = 1; p <= 3; p++) drive_pos(p);
    for (int i = 0; i < 3; i++) drive_pos(3);

    // Gaps: valid_in low with random codes present.
    for (int i = 0; i < 3; i++) drive(W'($urandom_range(0, 15)), 1'b0, 1'b0);

    // Saturate err_count with repeated skips.
    for (int i = 0; i < 262; i++) drive_pos((i % 2) * 4);
    check_eq("saturate_255", err_count_o[0], 255);
    drive_pos(0);
    drive(seq_tbl[4], 1'b1, 1'b1);
    check_eq("clr_wins", err_count_o[0], 0);

    // Randomized traffic.
    pos = 0;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) drive(W'($urandom_range(0, 15)), 1'b0, ($urandom_range(0, 29) == 0));
      else if (r < 20) drive(W'($urandom_range(0, 15)), 1'b1, ($urandom_range(0, 29) == 0));
      else if (r < 28) drive(seq_tbl[pos], 1'b1, 1'b0);
      else if (r < 33) begin pos = $urandom_range(0, N - 1); drive(seq_tbl[pos], 1'b1, 1'b0); end
      else begin pos = (pos + 1) % N; drive(seq_tbl[pos], 1'b1, 1'b0); end
    end

    // Lock, build some errors, then an asynchronous reset between edges.
    drive(4'b1010, 1'b1, 1'b0);
    for (int p = 0; p < 7; p++) drive_pos(p);
    drive_pos(3);
    for (int p = 4; p < 10; p++) drive_pos(p);
    check_eq("pre_reset_locked", locked_o[0], 1);
    @(negedge clock);
    valid_in = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1 check_all();
    check_eq("async_locked", locked_o[0], 0);
    #1 reset = 1'b0;
    for (int p = 0; p < 6; p++) drive_pos(p);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
